// File: rtl/spart_driver.sv
// SPART driver: programs the baud divisor from the DIP switches, then echoes
// every received byte back out through the SPART bus. Registered Moore FSM;
// every bus output is a flop loaded with the value for the state being entered.
module spart_driver #(
  parameter logic [15:0] DB_4800  = 16'h0515,
  parameter logic [15:0] DB_9600  = 16'h028A,
  parameter logic [15:0] DB_19200 = 16'h0145,
  parameter logic [15:0] DB_38400 = 16'h00A2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] br_cfg,
  input  logic       rda,
  input  logic       tbr,
  input  logic [7:0] data_in,
  output logic       iocs,
  output logic       iorw,
  output logic [1:0] ioaddr,
  output logic [7:0] data_out,
  output logic [7:0] echo_count
);

  typedef enum logic [2:0] {
    LOAD_LO  = 3'd0,
    LOAD_HI  = 3'd1,
    WAIT_RDA = 3'd2,
    READ     = 3'd3,
    WAIT_TBR = 3'd4,
    WRITE    = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic        started_q;
  logic [1:0]  cfg_q;
  logic [7:0]  byte_q;
  logic        iocs_q, iorw_q;
  logic [1:0]  ioaddr_q;
  logic [7:0]  data_out_q;
  logic [7:0]  echo_count_q;
  logic [15:0] db_new_s;
  logic [15:0] db_cur_s;

  // Map a baud select code to its divisor.
  function automatic logic [15:0] db_sel(input logic [1:0] sel);
    logic [15:0] db;
    case (sel)
      2'b00:   db = DB_4800;
      2'b01:   db = DB_9600;
      2'b10:   db = DB_19200;
      2'b11:   db = DB_38400;
      default: db = DB_9600;
    endcase
    return db;
  endfunction

  // Low byte comes from the live switches (latched on LOAD_LO entry),
  // high byte from the latched copy so both halves always match.
  assign db_new_s = db_sel(br_cfg);
  assign db_cur_s = db_sel(cfg_q);

  // Next-state decision. Out of reset the FSM spends one extra edge in
  // LOAD_LO so the first post-reset edge registers the LOAD_LO outputs.
  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD_LO: begin
        if (started_q) state_d = LOAD_HI;
        else           state_d = LOAD_LO;
      end
      LOAD_HI:  state_d = WAIT_RDA;
      WAIT_RDA: begin
        if (rda)                  state_d = READ;
        else if (br_cfg != cfg_q) state_d = LOAD_LO;
        else                      state_d = WAIT_RDA;
      end
      READ:     state_d = WAIT_TBR;
      WAIT_TBR: begin
        if (tbr) state_d = WRITE;
        else     state_d = WAIT_TBR;
      end
      WRITE:    state_d = WAIT_RDA;
      default:  state_d = LOAD_LO;
    endcase
  end

  // State, data registers and registered bus outputs for the state being entered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= LOAD_LO;
      started_q    <= 1'b0;
      cfg_q        <= 2'b00;
      byte_q       <= 8'h00;
      iocs_q       <= 1'b0;
      iorw_q       <= 1'b1;
      ioaddr_q     <= 2'b00;
      data_out_q   <= 8'h00;
      echo_count_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      started_q <= 1'b1;
      if (state_q == READ) begin
        byte_q <= data_in;
      end
      case (state_d)
        LOAD_LO: begin
          cfg_q      <= br_cfg;
          iocs_q     <= 1'b1;
          iorw_q     <= 1'b0;
          ioaddr_q   <= 2'b10;
          data_out_q <= db_new_s[7:0];
        end
        LOAD_HI: begin
          iocs_q     <= 1'b1;
          iorw_q     <= 1'b0;
          ioaddr_q   <= 2'b11;
          data_out_q <= db_cur_s[15:8];
        end
        READ: begin
          iocs_q     <= 1'b1;
          iorw_q     <= 1'b1;
          ioaddr_q   <= 2'b00;
          data_out_q <= 8'h00;
        end
        WRITE: begin
          iocs_q       <= 1'b1;
          iorw_q       <= 1'b0;
          ioaddr_q     <= 2'b00;
          data_out_q   <= byte_q;
          echo_count_q <= echo_count_q + 8'd1;
        end
        default: begin
          iocs_q     <= 1'b0;
          iorw_q     <= 1'b1;
          ioaddr_q   <= 2'b00;
          data_out_q <= 8'h00;
        end
      endcase
    end
  end

  assign iocs       = iocs_q;
  assign iorw       = iorw_q;
  assign ioaddr     = ioaddr_q;
  assign data_out   = data_out_q;
  assign echo_count = echo_count_q;

endmodule
